// File: rtl/lsu_data_mem.sv
// Load/store responder with a word-organised synchronous data RAM.
// Word-crossing accesses are split into two word accesses while stall holds the core.
module lsu_data_mem #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        L_type_en,
  input  logic        Mem_write_en,
  input  logic [2:0]  Load_type,
  input  logic [1:0]  Store_type,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        err
);

  typedef enum logic [2:0] {S_IDLE, S_RD1, S_FMT, S_WR1, S_DONE} state_t;

  localparam logic [2:0] LB  = 3'd0;
  localparam logic [2:0] LH  = 3'd1;
  localparam logic [2:0] LBU = 3'd3;
  localparam logic [2:0] LHU = 3'd4;

  state_t state, state_next;

  logic             illegal, legal_load, legal_store;
  logic [2:0]       req_size;
  logic [3:0]       size_mask;
  logic [1:0]       req_off;
  logic [IDX_W-1:0] req_idx;
  logic             req_mis;
  logic [63:0]      st_shift;
  logic [7:0]       be_shift;

  // Request fields held for the later cycles of a split access
  logic             op_load_q, mis_q;
  logic [2:0]       ltype_q;
  logic [1:0]       off_q;
  logic [IDX_W-1:0] idx0_q;
  logic [31:0]      st_hi_q;
  logic [3:0]       be1_q;
  logic [31:0]      word0_q;

  logic [31:0]      mem [DEPTH_WORDS];
  logic [31:0]      rdata;
  logic             rd_en, wr_en;
  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [31:0]      wr_data;
  logic [3:0]       wr_be;

  logic [63:0]      pair;
  logic [31:0]      fmt_word, fmt_data;

  // Upper address bits are ignored: the word index wraps
  logic unused;
  assign unused = ^addr[31:IDX_W+2];

  assign illegal = (L_type_en && Mem_write_en)
                || (L_type_en && (Load_type > 3'd4))
                || (Mem_write_en && (Store_type == 2'd3));
  assign legal_load  = L_type_en && !illegal;
  assign legal_store = Mem_write_en && !illegal;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    req_size = 3'd4;
    if (L_type_en) begin
      case (Load_type)
        LB, LBU: req_size = 3'd1;
        LH, LHU: req_size = 3'd2;
        default: req_size = 3'd4;
      endcase
    end else begin
      case (Store_type)
        2'd0:    req_size = 3'd1;
        2'd1:    req_size = 3'd2;
        default: req_size = 3'd4;
      endcase
    end
  end

  assign size_mask = (req_size == 3'd1) ? 4'b0001 :
                     (req_size == 3'd2) ? 4'b0011 : 4'b1111;
  assign req_off   = addr[1:0];
  assign req_idx   = addr[IDX_W+1:2];
  assign req_mis   = ({2'b00, req_off} + {1'b0, req_size}) > 4'd4;
  assign st_shift  = {32'd0, store_data} << {req_off, 3'b000};
  assign be_shift  = {4'd0, size_mask} << req_off;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (legal_load)       state_next = req_mis ? S_RD1 : S_FMT;
        else if (legal_store) state_next = req_mis ? S_WR1 : S_DONE;
      end
      S_RD1:   state_next = S_FMT;
      S_FMT:   state_next = S_DONE;
      S_WR1:   state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    stall   = 1'b0;
    rd_en   = 1'b0;
    rd_idx  = req_idx;
    wr_en   = 1'b0;
    wr_idx  = req_idx;
    wr_data = st_shift[31:0];
    wr_be   = be_shift[3:0];
    case (state)
      S_IDLE: begin
        stall = legal_load || legal_store;
        rd_en = legal_load;
        wr_en = legal_store;
      end
      S_RD1: begin
        stall  = 1'b1;
        rd_en  = 1'b1;
        rd_idx = idx0_q + IDX_W'(1);
      end
      S_FMT: stall = 1'b1;
      S_WR1: begin
        stall   = 1'b1;
        wr_en   = 1'b1;
        wr_idx  = idx0_q + IDX_W'(1);
        wr_data = st_hi_q;
        wr_be   = be1_q;
      end
      default: stall = 1'b0;
    endcase
  end

  // NOTE: RAM contents are never reset; only the write is suppressed while rst is high.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
    if (rd_en) rdata <= mem[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (state == S_IDLE && (legal_load || legal_store)) begin
      op_load_q <= legal_load;
      ltype_q   <= Load_type;
      off_q     <= req_off;
      idx0_q    <= req_idx;
      mis_q     <= req_mis;
      st_hi_q   <= st_shift[63:32];
      be1_q     <= be_shift[7:4];
    end
    if (state == S_RD1) word0_q <= rdata;
  end

  // On a split load, rdata holds word1 by FMT and word0 was captured in RD1
  assign pair     = {rdata, mis_q ? word0_q : rdata};
  assign fmt_word = 32'(pair >> {off_q, 3'b000});

  always_comb begin
    case (ltype_q)
      LB:      fmt_data = {{24{fmt_word[7]}}, fmt_word[7:0]};
      LH:      fmt_data = {{16{fmt_word[15]}}, fmt_word[15:0]};
      LBU:     fmt_data = {24'd0, fmt_word[7:0]};
      LHU:     fmt_data = {16'd0, fmt_word[15:0]};
      default: fmt_data = fmt_word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load_data <= 32'd0;
      err       <= 1'b0;
    end else begin
      err <= (state == S_IDLE) && illegal;
      if (state == S_FMT) load_data <= fmt_data;
    end
  end

  assign load_valid = (state == S_DONE) && op_load_q;

endmodule

// File: tb/tb_lsu_data_mem.sv
// Self-checking bench for lsu_data_mem: directed vector table, corner sequences,
// and randomized traffic against a byte-addressed reference memory.
module tb_lsu_data_mem;

  localparam int DEPTH_WORDS = 1024;
  localparam int IDX_W       = 10;
  localparam int NBYTES      = 4 * DEPTH_WORDS;

  logic        clk = 1'b0;
  logic        rst;
  logic        L_type_en, Mem_write_en;
  logic [2:0]  Load_type;
  logic [1:0]  Store_type;
  logic [31:0] addr, store_data;
  logic        stall, load_valid, err;
  logic [31:0] load_data;

  lsu_data_mem #(.DEPTH_WORDS(DEPTH_WORDS), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst),
    .L_type_en(L_type_en), .Mem_write_en(Mem_write_en),
    .Load_type(Load_type), .Store_type(Store_type),
    .addr(addr), .store_data(store_data),
    .stall(stall), .load_data(load_data), .load_valid(load_valid), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  ref_mem [NBYTES];
  logic [31:0] last_ld = 32'd0;

  typedef struct {
    bit          is_ld;
    logic [2:0]  lt;
    logic [1:0]  st;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int lsize(input logic [2:0] lt);
    if (lt == 3'd0 || lt == 3'd3) return 1;
    if (lt == 3'd1 || lt == 3'd4) return 2;
    return 4;
  endfunction

  function automatic int ssize(input logic [1:0] st);
    if (st == 2'd0) return 1;
    if (st == 2'd1) return 2;
    return 4;
  endfunction

  // Loads read consecutive bytes of a flat byte space that wraps at NBYTES
  function automatic logic [31:0] model_load(input logic [2:0] lt, input logic [31:0] a);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < lsize(lt); i++) v[8*i +: 8] = ref_mem[(a + 32'(i)) & 32'(NBYTES - 1)];
    if (lt == 3'd0) v = {{24{v[7]}}, v[7:0]};
    if (lt == 3'd1) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic idle_inputs();
    L_type_en = 1'b0; Mem_write_en = 1'b0;
    Load_type = 3'd0; Store_type = 2'd0;
    addr = 32'd0; store_data = 32'd0;
  endtask

  task automatic run_op(input string tag, input bit is_ld, input logic [2:0] lt,
                        input logic [1:0] st, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] got);
    int size, exp_lat, lat;
    logic [31:0] exp_ld;
    bit done;
    size    = is_ld ? lsize(lt) : ssize(st);
    exp_lat = (int'(a[1:0]) + size > 4) ? (is_ld ? 3 : 2) : (is_ld ? 2 : 1);
    exp_ld  = is_ld ? model_load(lt, a) : last_ld;
    if (!is_ld)
      for (int i = 0; i < size; i++) ref_mem[(a + 32'(i)) & 32'(NBYTES - 1)] = d[8*i +: 8];
    @(negedge clk);
    L_type_en = is_ld; Mem_write_en = !is_ld;
    Load_type = lt; Store_type = st; addr = a; store_data = d;
    #1 check({tag, " stall_accept"}, 32'(stall), 32'd1);
    lat = 0; done = 1'b0;
    for (int c = 1; c <= 6 && !done; c++) begin
      @(negedge clk);
      if (!stall) begin
        done = 1'b1;
        lat  = c;
      end
    end
    got = load_data;
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " load_valid"}, 32'(load_valid), 32'(is_ld));
    check({tag, " load_data"}, load_data, exp_ld);
    last_ld = exp_ld;
    idle_inputs();
  endtask

  task automatic run_illegal(input string tag, input logic l, input logic w,
                             input logic [2:0] lt, input logic [1:0] st, input logic [31:0] a);
    @(negedge clk);
    L_type_en = l; Mem_write_en = w; Load_type = lt; Store_type = st;
    addr = a; store_data = 32'd0;
    #1 check({tag, " stall"}, 32'(stall), 32'd0);
    @(negedge clk);
    check({tag, " err_pulse"}, 32'(err), 32'd1);
    check({tag, " no_valid"}, 32'(load_valid), 32'd0);
    check({tag, " data_held"}, load_data, last_ld);
    idle_inputs();
    @(negedge clk);
    check({tag, " err_clear"}, 32'(err), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got, r, a;
    int off;
    bit is_ld;
    logic [2:0] lt;
    logic [1:0] st;

    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset stall", 32'(stall), 32'd0);
    check("reset load_valid", 32'(load_valid), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset load_data", load_data, 32'd0);
    rst = 1'b0;

    vecs.push_back('{1'b0, 3'd0, 2'd2, 32'h10,   32'h80FF7F01, 32'h0,        "sw_10"});
    vecs.push_back('{1'b1, 3'd0, 2'd0, 32'h13,   32'h0,        32'hFFFFFF80, "lb_13"});
    vecs.push_back('{1'b1, 3'd3, 2'd0, 32'h13,   32'h0,        32'h00000080, "lbu_13"});
    vecs.push_back('{1'b1, 3'd1, 2'd0, 32'h12,   32'h0,        32'hFFFF80FF, "lh_12"});
    vecs.push_back('{1'b1, 3'd4, 2'd0, 32'h10,   32'h0,        32'h00007F01, "lhu_10"});
    vecs.push_back('{1'b1, 3'd2, 2'd0, 32'h10,   32'h0,        32'h80FF7F01, "lw_10"});
    vecs.push_back('{1'b0, 3'd0, 2'd2, 32'h20,   32'h11223344, 32'h0,        "sw_20"});
    vecs.push_back('{1'b0, 3'd0, 2'd0, 32'h21,   32'h000000AB, 32'h0,        "sb_21"});
    vecs.push_back('{1'b1, 3'd2, 2'd0, 32'h20,   32'h0,        32'h1122AB44, "lw_20a"});
    vecs.push_back('{1'b0, 3'd0, 2'd1, 32'h22,   32'h0000BEEF, 32'h0,        "sh_22"});
    vecs.push_back('{1'b1, 3'd2, 2'd0, 32'h20,   32'h0,        32'hBEEFAB44, "lw_20b"});
    vecs.push_back('{1'b0, 3'd0, 2'd2, 32'h30,   32'h0,        32'h0,        "sw_30"});
    vecs.push_back('{1'b0, 3'd0, 2'd2, 32'h34,   32'h0,        32'h0,        "sw_34"});
    vecs.push_back('{1'b0, 3'd0, 2'd2, 32'h33,   32'hDEADBEEF, 32'h0,        "sw_33_mis"});
    vecs.push_back('{1'b1, 3'd2, 2'd0, 32'h30,   32'h0,        32'hEF000000, "lw_30"});
    vecs.push_back('{1'b1, 3'd2, 2'd0, 32'h34,   32'h0,        32'h00DEADBE, "lw_34"});
    vecs.push_back('{1'b1, 3'd2, 2'd0, 32'h33,   32'h0,        32'hDEADBEEF, "lw_33_mis"});
    vecs.push_back('{1'b0, 3'd0, 2'd2, 32'hFFC,  32'h44332211, 32'h0,        "sw_top"});
    vecs.push_back('{1'b0, 3'd0, 2'd2, 32'h0,    32'h88776655, 32'h0,        "sw_0"});
    vecs.push_back('{1'b1, 3'd1, 2'd0, 32'hFFF,  32'h0,        32'h00005544, "lh_wrap"});
    vecs.push_back('{1'b1, 3'd4, 2'd0, 32'h1FFF, 32'h0,        32'h00005544, "lhu_wrap_alias"});
    vecs.push_back('{1'b1, 3'd2, 2'd0, 32'h1000, 32'h0,        32'h88776655, "lw_alias_1000"});

    foreach (vecs[i]) begin
      run_op(vecs[i].name, vecs[i].is_ld, vecs[i].lt, vecs[i].st, vecs[i].a, vecs[i].d, got);
      if (vecs[i].is_ld) check({vecs[i].name, " table"}, got, vecs[i].exp);
    end

    // Illegal requests must leave word 8 (0xBEEFAB44) untouched
    run_illegal("ill_both", 1'b1, 1'b1, 3'd2, 2'd2, 32'h20);
    run_op("rb_both", 1'b1, 3'd2, 2'd0, 32'h20, 32'h0, got);
    check("rb_both table", got, 32'hBEEFAB44);
    run_illegal("ill_lt6", 1'b1, 1'b0, 3'd6, 2'd0, 32'h20);
    run_illegal("ill_st3", 1'b0, 1'b1, 3'd0, 2'd3, 32'h20);
    run_op("rb_st3", 1'b1, 3'd2, 2'd0, 32'h20, 32'h0, got);
    check("rb_st3 table", got, 32'hBEEFAB44);

    // Reset during the second half of a split store
    run_op("z40", 1'b0, 3'd0, 2'd2, 32'h40, 32'h0, got);
    run_op("z44", 1'b0, 3'd0, 2'd2, 32'h44, 32'h0, got);
    @(negedge clk);
    Mem_write_en = 1'b1; Store_type = 2'd2; addr = 32'h41; store_data = 32'h12345678;
    #1 check("rst_mid stall_accept", 32'(stall), 32'd1);
    @(negedge clk);
    check("rst_mid stall_wr1", 32'(stall), 32'd1);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid stall", 32'(stall), 32'd0);
    check("rst_mid load_valid", 32'(load_valid), 32'd0);
    check("rst_mid load_data", load_data, 32'd0);
    ref_mem[32'h41] = 8'h78; ref_mem[32'h42] = 8'h56; ref_mem[32'h43] = 8'h34;
    last_ld = 32'd0;
    run_op("rst_rd40", 1'b1, 3'd2, 2'd0, 32'h40, 32'h0, got);
    check("rst_rd40 table", got, 32'h34567800);
    run_op("rst_rd44", 1'b1, 3'd2, 2'd0, 32'h44, 32'h0, got);
    check("rst_rd44 table", got, 32'h00000000);

    // Randomized traffic over words 64..79 with random ignored upper address bits
    for (int w = 0; w < 16; w++)
      run_op("rnd_init", 1'b0, 3'd0, 2'd2, 32'h100 + 32'(4 * w), $urandom, got);
    for (int n = 0; n < 250; n++) begin
      r     = $urandom;
      off   = int'($urandom_range(0, 60));
      a     = (r & 32'hFFFF_F000) | (32'h100 + 32'(off));
      is_ld = 1'($urandom_range(0, 1));
      lt    = 3'($urandom_range(0, 4));
      st    = 2'($urandom_range(0, 2));
      run_op(is_ld ? "rnd_ld" : "rnd_st", is_ld, lt, st, a, $urandom, got);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lsu_data_mem.md
Name: lsu_data_mem

Overview:
- Load/store responder on the data side of the RV32I single-cycle datapath.
- Consumes the control unit's memory-side outputs (L_type_en, Mem_write_en, Load_type, Store_type), the ALU effective address and the rs2 store data.
- Owns a word-organised synchronous data RAM and returns formatted load data for the WB_Sel=0 writeback path.
- Handles word-crossing (misaligned) accesses by splitting them into two word accesses, and holds the core with a stall until the access completes.

Parameters:
DEPTH_WORDS, 1024, data RAM size in 32-bit words (power of two)
IDX_W, 10, log2(DEPTH_WORDS), width of the word index

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-high
L_type_en  in  1  load request
Mem_write_en  in  1  store request
Load_type  in  3  0=LB 1=LH 2=LW 3=LBU 4=LHU
Store_type  in  2  0=SB 1=SH 2=SW
addr  in  32  byte address (ALU result)
store_data  in  32  rs2 value
stall  out  1  hold PC/pipeline while 1
load_data  out  32  formatted load result (registered)
load_valid  out  1  one-cycle pulse; load_data valid for writeback
err  out  1  one-cycle pulse on illegal request

Behaviour:
- Reset values: state=IDLE, stall=0, load_data=0, load_valid=0, err=0. RAM contents are not reset. Reset mid-operation aborts to IDLE; a word-0 write already performed stays, a pending word-1 write is dropped.
- Word index = addr[IDX_W+1:2] modulo DEPTH_WORDS; upper bits ignored (wrap). Byte offset off=addr[1:0]. Little-endian.
- Misaligned = LH/LHU/SH with off=3, or LW/SW with off!=0. Word1 index = word0+1, wrapping from DEPTH_WORDS-1 to 0.
- stall = (state!=IDLE && state!=DONE) || (state==IDLE && legal request present).
- FSM states: IDLE, RD1, FMT, WR1, DONE. Requests are sampled only in IDLE; the core holds the same request while stall=1.
- IDLE, legal load: issue read of word0. Next state is RD1 if misaligned, else FMT.
- RD1: capture word0, issue read of word1, go to FMT.
- FMT: assemble the bytes from word0 (and word1 if misaligned), extract starting at off, and extend. LB/LH sign-extend; LBU/LHU zero-extend; LW takes the full word. Register the result into load_data, go to DONE.
- IDLE, legal store: write word0 with byte enables for lanes off..min(off+size-1,3), using store_data shifted left by off bytes. Next state is WR1 if misaligned, else DONE.
- WR1: write the remaining lanes 0..(off+size-5) of word1 with the upper store bytes, go to DONE.
- DONE: stall=0; load_valid=1 only if the operation was a load; inputs are ignored; go to IDLE.
- Latency from accept cycle T: aligned store done at T+1; misaligned store done at T+2; aligned load valid at T+2; misaligned load valid at T+3.
- Illegal requests: L_type_en and Mem_write_en both set, Load_type>4, or Store_type=3. Response: no RAM access, err=1 for one cycle, stall=0, stay IDLE, load_data unchanged.
- load_data holds its value until the next load completes.

Test Plan:
- Write 0x80FF7F01 to word 4 with SW at addr 0x10, then LB/LBU/LH/LHU/LW at 0x10..0x13. Expect LB@0x13=0xFFFFFF80, LBU@0x13=0x00000080, LH@0x12=0xFFFF80FF, LHU@0x10=0x00007F01, LW@0x10=0x80FF7F01. Aligned loads give load_valid at T+2; stall is high for T and T+1.
- SB 0xAB at 0x21 over a word holding 0x11223344, then LW 0x20. Expect 0x1122AB44. SH 0xBEEF at 0x22, then LW. Expect 0xBEEFAB44.
- Misaligned SW 0xDEADBEEF at 0x33 with words 12 and 13 pre-zeroed. Expect word12=0xEF000000 and word13=0x00DEADBE; stall is high for 2 cycles. LW at 0x33 returns 0xDEADBEEF with load_valid at T+3.
- Word-index wrap: LH at byte address 4*DEPTH_WORDS-1 uses the top word's byte 3 and word 0's byte 0. Address 0x0000_1000 with DEPTH_WORDS=1024 aliases to word 0.
- Illegal requests: L_type_en=Mem_write_en=1, Load_type=6, and Store_type=3. Each gives an err pulse, stall=0, and an unchanged RAM (read back to confirm).
- Assert rst during WR1 of a misaligned SW. Expect word0 lanes written, word1 unchanged, and state IDLE/stall=0 on the next cycle.
